varclk_bank: RTL and testbench

Multi-channel successor to the single variable-clock manager. Holds NCH independent programmable dividers off `sysclk`. Each divider is reloaded from a serially shifted frequency frame, and each reload is applied glitch-free at that channel's next half-period boundary. Sits between the button and serial test-input front end and the board's PIO outputs; it generates the variable test clocks and reports when each reload has taken effect.

---
 rtl/varclk_bank.sv | 111 +++++++++++
 tb/tb_varclk_bank.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/varclk_bank.sv
// Bank of NCH programmable clock dividers, reloaded from a serial frame and switched glitch-free.
// Define VARCLK_BCAST_EN to treat channel index all-ones as a broadcast reload.
module varclk_bank #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned CH_W      = 2,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned RESET_DIV = 0
) (
    input  logic           sysclk,
    input  logic           reset,
    input  logic           FreqData_in,
    input  logic           FreqData_valid,
    input  logic           NewDataReady_in,
    output logic [NCH-1:0] varclk,
    output logic           NewDataReady_out,
    output logic           busy,
    output logic           load_err
);

    localparam int unsigned FRAME_W = CH_W + DIV_W;

    logic [FRAME_W-1:0] frame_q;
    logic               nd_q;
    logic [DIV_W-1:0]   pend_div_q;
    logic [NCH-1:0]     pend_mask_q, pend_mask_d;
    logic               err_q, done_q;

    logic [CH_W-1:0]    frame_ch;
    logic               commit_edge, ch_in_range, is_bcast, accept, reject;
    logic [NCH-1:0]     tgt_mask, apply;

    assign frame_ch    = frame_q[FRAME_W-1 -: CH_W];
    assign commit_edge = NewDataReady_in & ~nd_q;
    assign ch_in_range = (32'(frame_ch) < NCH);

`ifdef VARCLK_BCAST_EN
    assign is_bcast = (frame_ch == {CH_W{1'b1}});
`else
    assign is_bcast = 1'b0;
`endif

    assign busy     = |pend_mask_q;
    assign accept   = commit_edge & ~busy & (ch_in_range | is_bcast);
    assign reject   = commit_edge & ~accept;
    assign tgt_mask = is_bcast ? {NCH{1'b1}} : (NCH'(1) << frame_ch);

    // Channels drop out of the pending mask as they apply; busy is simply "any left".
    always_comb begin
        pend_mask_d = pend_mask_q & ~apply;
        if (accept) begin
            pend_mask_d = tgt_mask;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            frame_q     <= '0;
            nd_q        <= 1'b0;
            pend_div_q  <= '0;
            pend_mask_q <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (FreqData_valid) begin
                frame_q <= {frame_q[FRAME_W-2:0], FreqData_in};
            end
            nd_q <= NewDataReady_in;
            if (accept) begin
                pend_div_q <= frame_q[DIV_W-1:0];
            end
            pend_mask_q <= pend_mask_d;
            if (reject) begin
                err_q <= 1'b1;
            end
            done_q <= busy & ~(|pend_mask_d);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DIV_W-1:0] div_q, cnt_q;
        logic             clk_q;
        logic             running, boundary;

        assign running  = (div_q != '0);
        assign boundary = running & (cnt_q == div_q);
        // A disabled channel takes its reload at once; a running one waits for its edge.
        assign apply[i] = pend_mask_q[i] & (~running | boundary);
        assign varclk[i] = clk_q;

        always_ff @(posedge sysclk) begin
            if (!reset) begin
                div_q <= DIV_W'(RESET_DIV);
                cnt_q <= '0;
                clk_q <= 1'b0;
            end else if (apply[i]) begin
                div_q <= pend_div_q;
                cnt_q <= '0;
                clk_q <= (pend_div_q != '0) ? (clk_q ^ boundary) : 1'b0;
            end else if (boundary) begin
                clk_q <= ~clk_q;
                cnt_q <= '0;
            end else if (running) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign NewDataReady_out = done_q;
    assign load_err         = err_q;

endmodule

// File: tb/tb_varclk_bank.sv
// Randomised bench for varclk_bank: a time-based reference model predicts every output and a
// scoreboard queue holds the cycle at which each completion pulse is due.
module tb_varclk_bank;

    localparam int NCH   = 4;
    localparam int CH_W  = 3;
    localparam int DIV_W = 16;
    localparam int FW    = CH_W + DIV_W;

    logic           sysclk = 1'b0;
    logic           reset  = 1'b0;
    logic           fd     = 1'b0;
    logic           fv     = 1'b0;
    logic           nd     = 1'b0;
    logic [NCH-1:0] varclk;
    logic           ndo, busy, lerr;

    int tests = 0;
    int fails = 0;

    always #5 sysclk = ~sysclk;

    varclk_bank #(
        .NCH(NCH), .CH_W(CH_W), .DIV_W(DIV_W), .RESET_DIV(0)
    ) dut (
        .sysclk          (sysclk),
        .reset           (reset),
        .FreqData_in     (fd),
        .FreqData_valid  (fv),
        .NewDataReady_in (nd),
        .varclk          (varclk),
        .NewDataReady_out(ndo),
        .busy            (busy),
        .load_err        (lerr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each running channel is described by its level, its half period and the
    // absolute edge number of its next toggle.
    int      cyc = 0;
    bit      started = 0;
    int      m_div  [NCH];
    bit      m_lvl  [NCH];
    int      m_next [NCH];
    bit      m_pend [NCH];
    int      m_pdiv;
    bit      m_err;
    bit      m_prev_nd;
    bit [FW-1:0] m_frame;
    int      exp_q[$];

    always @(posedge sysclk) begin : model
        bit was_busy, now_busy, commit;
        int ch, dv;
        cyc++;
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_div[i] = 0; m_lvl[i] = 0; m_next[i] = 0; m_pend[i] = 0;
            end
            m_pdiv = 0; m_err = 0; m_prev_nd = 0; m_frame = '0;
            started = 1;
        end else begin
            was_busy = 0;
            for (int i = 0; i < NCH; i++) was_busy |= m_pend[i];
            for (int i = 0; i < NCH; i++) begin
                if (m_div[i] == 0) begin
                    if (m_pend[i]) begin
                        m_pend[i] = 0;
                        m_div[i]  = m_pdiv;
                        m_lvl[i]  = 0;
                        m_next[i] = cyc + m_pdiv + 1;
                    end
                end else if (cyc == m_next[i]) begin
                    if (m_pend[i]) begin
                        m_pend[i] = 0;
                        m_div[i]  = m_pdiv;
                    end
                    if (m_div[i] == 0) begin
                        m_lvl[i] = 0;
                    end else begin
                        m_lvl[i]  = !m_lvl[i];
                        m_next[i] = cyc + m_div[i] + 1;
                    end
                end
            end
            now_busy = 0;
            for (int i = 0; i < NCH; i++) now_busy |= m_pend[i];
            if (was_busy && !now_busy) exp_q.push_back(cyc);

            commit = nd && !m_prev_nd;
            ch = int'(m_frame[FW-1:DIV_W]);
            dv = int'(m_frame[DIV_W-1:0]);
            if (commit) begin
                if (was_busy) begin
                    m_err = 1;
                end else if (ch < NCH) begin
                    m_pend[ch] = 1;
                    m_pdiv     = dv;
`ifdef VARCLK_BCAST_EN
                end else if (ch == (1 << CH_W) - 1) begin
                    for (int i = 0; i < NCH; i++) m_pend[i] = 1;
                    m_pdiv = dv;
`endif
                end else begin
                    m_err = 1;
                end
            end
            m_prev_nd = nd;
            if (fv) m_frame = {m_frame[FW-2:0], fd};
        end
    end

    // Monitor: compares levels every cycle and matches each completion pulse to the queue.
    always @(negedge sysclk) begin : monitor
        logic [NCH-1:0] ev;
        bit eb;
        int e;
        if (started) begin
            eb = 0;
            for (int i = 0; i < NCH; i++) begin
                ev[i] = m_lvl[i];
                eb |= m_pend[i];
            end
            check("varclk", 64'(varclk), 64'(ev));
            check("busy", 64'(busy), 64'(eb));
            check("load_err", 64'(lerr), 64'(m_err));
            if (ndo === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                check("ndr_out_cycle", 64'(cyc), 64'(e));
            end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
                void'(exp_q.pop_front());
                check("ndr_out_missing", 64'(ndo), 64'd1);
            end
        end
    end

    task automatic shift_frame(input int ch, input int dv);
        bit [FW-1:0] f;
        f = {ch[CH_W-1:0], dv[DIV_W-1:0]};
        for (int b = FW - 1; b >= 0; b--) begin
            @(negedge sysclk);
            fd = f[b];
            fv = 1'b1;
        end
        @(negedge sysclk);
        fv = 1'b0;
    endtask

    task automatic pulse_commit(input int hold, input bit noise);
        @(negedge sysclk);
        nd = 1'b1;
        if (noise) begin
            fv = 1'b1;
            fd = 1'($urandom_range(0, 1));
        end
        @(negedge sysclk);
        fv = 1'b0;
        repeat (hold - 1) @(negedge sysclk);
        nd = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge sysclk);
            k++;
        end
        check("idle_within_budget", 64'(busy), 64'd0);
        repeat (2) @(negedge sysclk);
    endtask

    task automatic load(input int ch, input int dv);
        shift_frame(ch, dv);
        pulse_commit(1, 0);
        wait_idle(100);
    endtask

    initial begin : stim
        repeat (3) @(negedge sysclk);
        reset = 1'b1;
        repeat (4) @(negedge sysclk);

        // First load from a disabled channel, then run several periods.
        load(1, 3);
        repeat (20) @(negedge sysclk);

        // Retune a running channel mid-period.
        shift_frame(1, 9);
        repeat (2) @(negedge sysclk);
        pulse_commit(1, 0);
        wait_idle(100);
        repeat (30) @(negedge sysclk);

        // Disable a running channel.
        load(1, 0);
        repeat (10) @(negedge sysclk);

        // Edge while busy, then an out-of-range channel.
        load(2, 4);
        shift_frame(2, 6);
        pulse_commit(1, 0);
        pulse_commit(1, 0);
        wait_idle(100);
        load(5, 7);
        repeat (10) @(negedge sysclk);

        // Reset between commit and apply.
        load(3, 5);
        shift_frame(3, 8);
        pulse_commit(1, 0);
        reset = 1'b0;
        @(negedge sysclk);
        reset = 1'b1;
        repeat (5) @(negedge sysclk);

        // Broadcast frame (rejected unless broadcast is built in).
        load(0, 1);
        load(1, 2);
        load(2, 5);
        load(3, 7);
        repeat (7) @(negedge sysclk);
        shift_frame((1 << CH_W) - 1, 4);
        pulse_commit(1, 0);
        wait_idle(100);
        repeat (20) @(negedge sysclk);

        // Held commit request yields one commit.
        shift_frame(0, 2);
        pulse_commit(6, 0);
        wait_idle(100);

        for (int it = 0; it < 40; it++) begin
            int ch, dv;
            ch = int'($urandom_range(0, (1 << CH_W) - 1));
            dv = int'($urandom_range(0, 10));
            shift_frame(ch, dv);
            repeat (int'($urandom_range(0, 6))) @(negedge sysclk);
            pulse_commit(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) pulse_commit(1, 0);
            if ($urandom_range(0, 14) == 0) begin
                reset = 1'b0;
                @(negedge sysclk);
                reset = 1'b1;
            end
            wait_idle(100);
            repeat (int'($urandom_range(0, 15))) @(negedge sysclk);
        end

        repeat (5) @(negedge sysclk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
